// File: rtl/definitions_pkg.sv
// Shared project definitions: clocking constants, UART defaults and receiver FSM states.
package definitions_pkg;

    localparam int unsigned CLOCK_RATE     = 50_000_000;
    localparam int unsigned BAUD_RATE      = 115_200;
    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: recovers start/data/parity/stop framing from the synchronizer's
// baud strobe and clean rx line, and holds each byte in a one-entry valid/ready register.
module uart_rx_deframer
    import definitions_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned      CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $fatal(1, "uart_rx_deframer: DATA_BITS must be 5..8");
    end

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 baud_q;
    logic                 samp;
    logic                 deliver_c;
    logic                 frame_err_c;
    logic                 load_c;
    logic                 overrun_c;

    // baud_q resets high so a baud already high at reset release is not a strobe
    assign samp = baud & ~baud_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q    <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            baud_q    <= baud;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    // Next-state: every transition and rx sample is qualified by samp
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        deliver_c   = 1'b0;
        frame_err_c = 1'b0;
        if (samp) begin
            case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_d   = {rx, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_bad_d = (^{shift_q, rx}) != PARITY_ODD;
                    state_d   = STOP;
                end
                STOP: begin
                    if (rx) begin
                        deliver_c = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_d     = BREAK;
                    end
                end
                BREAK: begin
                    if (rx) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A completed byte loads when the holding register is empty or draining this cycle
    assign load_c    = deliver_c & (~m_valid | m_ready);
    assign overrun_c = deliver_c & m_valid & ~m_ready;

    // Output holding register and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_parity_err <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load_c) begin
                m_data       <= shift_q;
                m_parity_err <= par_bad_q;
            end
            m_valid   <= load_c | (m_valid & ~m_ready);
            frame_err <= frame_err_c;
            overrun   <= overrun_c;
        end
    end

endmodule
